// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - memory-stage load/store unit bridging pipeline requests onto a valid/ready data bus
// Stalls the pipeline while a bus transfer is in flight; formats load data and flags misalignment/timeouts.
module lsu_bus_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluresultM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        misalignM,
  output logic        buserrM,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, stateNext;
  logic            req, sizeByte, sizeHalf, misaligned, timedOut;
  logic [1:0]      off, offQ;
  logic [2:0]      funct3Q;
  logic [3:0]      beNext;
  logic [31:0]     wdataNext, loadData;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [CW-1:0]   waitCnt;

  assign req        = memreadM | memwriteM;
  assign off        = aluresultM[1:0];
  assign sizeByte   = (funct3M[1:0] == 2'b00);
  assign sizeHalf   = (funct3M[1:0] == 2'b01);
  assign misaligned = (sizeHalf & off[0]) | (~sizeByte & ~sizeHalf & (off != 2'b00));
  // waitCnt counts completed BUSY cycles, so the TIMEOUT-th BUSY cycle is the last one
  assign timedOut   = (TIMEOUT != 0) && (waitCnt == CNT_LAST);

  always_comb begin
    beNext    = 4'b1111;
    wdataNext = writedataM;
    if (sizeByte) begin
      beNext    = 4'b0001 << off;
      wdataNext = {4{writedataM[7:0]}};
    end else if (sizeHalf) begin
      beNext    = 4'b0011 << off;
      wdataNext = {2{writedataM[15:0]}};
    end
  end

  assign loadByte = bus_rdata[{offQ, 3'b000} +: 8];
  assign loadHalf = offQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    case (funct3Q[1:0])
      2'b00:   loadData = {{24{~funct3Q[2] & loadByte[7]}}, loadByte};
      2'b01:   loadData = {{16{~funct3Q[2] & loadHalf[15]}}, loadHalf};
      default: loadData = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stallM    = 1'b0;
    misalignM = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (misaligned) begin
            misalignM = 1'b1;
          end else begin
            stallM    = 1'b1;
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (bus_ready || timedOut) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_valid <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      readdataM <= '0;
      buserrM   <= 1'b0;
      funct3Q   <= '0;
      offQ      <= '0;
      waitCnt   <= '0;
    end else begin
      buserrM <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !misaligned) begin
            bus_valid <= 1'b1;
            bus_we    <= memwriteM;
            bus_addr  <= {aluresultM[31:2], 2'b00};
            bus_be    <= beNext;
            bus_wdata <= wdataNext;
            funct3Q   <= funct3M;
            offQ      <= off;
          end
        end
        BUSY: begin
          if (waitCnt != CNT_MAX) waitCnt <= waitCnt + 1'b1;
          if (bus_ready) begin
            bus_valid <= 1'b0;
            if (!bus_we) readdataM <= loadData;
          end else if (timedOut) begin
            bus_valid <= 1'b0;
            readdataM <= '0;
            buserrM   <= 1'b1;
          end
        end
        DONE:    waitCnt <= '0;
        default: waitCnt <= '0;
      endcase
    end
  end

endmodule
